timer_irq_ctrl: RTL and testbench
=================================

# timer_irq_ctrl

Interrupt collector directly downstream of the timer block. It captures rising edges on the timerA/B/C and watchdog interrupt lines into sticky pending bits and applies per-source enables. It presents the highest-priority enabled event to the CPU with a request/acknowledge/end-of-interrupt handshake. It also turns the watchdog NMI pulse into a sticky NMI line.

## Interface
- NSRC, 4: number of maskable sources; bit 0 = timerA_irq, 1 = timerB_irq, 2 = timerC_irq, 3 = wdtimer_irq
- ID_W, $clog2(NSRC): width of irq_id
- hclk  in  1  single clock; all logic on posedge
- hreset  in  1  asynchronous, active-high reset; clears all state
- irq_src  in  NSRC  raw timer interrupt levels; pulses may be 1 cycle (timers) or 3 cycles (watchdog)
- wdtimer_nmi  in  1  raw watchdog NMI level
- en_wr  in  1  write strobe for enable register
- en_wdata  in  NSRC  new enable value
- clr_wr  in  1  write-1-to-clear strobe for pending and overflow
- clr_wdata  in  NSRC  bits to clear
- nmi_clr  in  1  clears nmi_out
- irq_ack  in  1  CPU acknowledge, 1-cycle pulse
- irq_eoi  in  1  CPU end-of-interrupt, 1-cycle pulse
- irq_req  out  1  interrupt request to CPU
- irq_id  out  ID_W  index of the presented source
- pending  out  NSRC  sticky pending bits, enable not applied
- overflow  out  NSRC  sticky "event lost" bits
- irq_en  out  NSRC  current enable register
- nmi_out  out  1  sticky NMI to CPU

## Operation
- Edge detect per source: src_q <= irq_src; rise = irq_src & ~src_q. A level held high counts as one event.
- Pending update: pending <= (pending & ~(clr_wr ? clr_wdata : 0) & ~ackclr) | rise.
  - ackclr is the one-hot bit of irq_id when irq_ack is accepted.
  - If a rise and a clear hit the same bit in the same cycle, set wins.
- Overflow: a rise on a bit that is already pending and not cleared that cycle sets overflow[i]. Only clr_wr clears overflow; the clear is ignored if a new overflow occurs in the same cycle.
- Active set: act = pending & irq_en. Priority is fixed: lowest index wins, so timerA is highest.
- FSM states:
  - IDLE: if act != 0, latch irq_id = lowest set bit of act and go to REQ.
  - REQ: irq_req = 1.
    - irq_ack: clear pending[irq_id] and go to SERVICE.
    - If act[irq_id] drops before ack (cleared or disabled): withdraw, irq_req = 0, return to IDLE. Withdraw takes precedence over an ack in the same cycle.
  - SERVICE: irq_req = 0; wait for irq_eoi, then go to IDLE. New events keep accumulating; nesting is not supported.
- irq_ack outside REQ and irq_eoi outside SERVICE are ignored.
- irq_id holds its value outside REQ; it is meaningful only while irq_req = 1.
- NMI: a rising edge of wdtimer_nmi sets nmi_out. nmi_clr clears it, with set winning on collision. The NMI path is independent of the enables and the FSM.

## Timing
- Reset values: irq_req 0, irq_id 0, pending 0, overflow 0, irq_en 0, nmi_out 0, src_q 0, FSM IDLE.
- Input high first sampled at edge k: pending set after edge k. FSM enters REQ at edge k+1, so irq_req is high from cycle k+1 (1-cycle latency from pending).
- irq_ack sampled at edge m: irq_req low and pending bit clear after edge m.
- irq_eoi at edge n: IDLE after n; the next REQ at the earliest after n+1.
- en_wr takes effect on the edge it is sampled; a disable of the presented source withdraws the request on the next edge.
- hreset asserted mid-handshake: everything returns to reset values immediately; in-flight events are lost.

## Structure
- Package timer_irq_pkg holds:
  - FSM state enum: IDLE, REQ, SERVICE
  - NSRC_DEF = 4
  - source index constants SRC_TA = 0, SRC_TB = 1, SRC_TC = 2, SRC_WDT = 3
- Sub-module irq_pend_cell, instantiated per source: edge detect, pending and overflow flops with the set-wins rule. The top holds the enable register, priority encoder, FSM and NMI latch.

## Test plan
- Enable 4'b1111; pulse irq_src[2] for 1 cycle at edge 10 -> pending = 4'b0100 after edge 10, irq_req = 1 and irq_id = 2 from cycle 11; ack at 15 -> pending 0, irq_req 0; eoi at 18 -> IDLE.
- Pulse sources 3 and 1 together -> irq_id = 1 first; after ack and eoi, irq_id = 3 presented.
- irq_src[3] held high 3 cycles (watchdog shape) -> exactly one pending event; a second rise before ack -> overflow = 4'b1000; clr_wr with 4'b1000 -> overflow and pending cleared.
- Enable 4'b0001; pulse source 0 and reach REQ; en_wr with 0 before ack -> irq_req drops next cycle, pending[0] stays 1; re-enable -> REQ again with irq_id = 0.
- Clear and rise on bit 0 in the same cycle -> pending[0] = 1. Ack in IDLE and eoi in REQ -> no state change.
- Pulse wdtimer_nmi with enables 0 -> nmi_out = 1, irq_req = 0; nmi_clr -> nmi_out 0. Assert hreset during SERVICE -> all outputs 0 immediately.

Source files
------------

// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer interrupt collector.
//   NSRC_DEF    : default number of maskable timer sources
//   SRC_*       : bit position of each timer source in irq_src/pending/irq_en
//   irq_state_t : request/acknowledge/end-of-interrupt handshake states
package timer_irq_pkg;

    localparam int NSRC_DEF = 4;

    localparam int SRC_TA  = 0;
    localparam int SRC_TB  = 1;
    localparam int SRC_TC  = 2;
    localparam int SRC_WDT = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_pend_cell.sv
// One interrupt source: rising-edge detect, sticky pending flag and sticky
// overflow ("event lost") flag.
// Ports:
//   hclk, hreset : clock, asynchronous active-high reset
//   src          : raw interrupt level from the timer
//   clr          : clear pending this cycle (register write or CPU acknowledge)
//   ovf_clr      : clear overflow this cycle (register write only)
//   pending      : sticky pending flag
//   overflow     : sticky overflow flag
module irq_pend_cell (
    input  logic hclk,
    input  logic hreset,
    input  logic src,
    input  logic clr,
    input  logic ovf_clr,
    output logic pending,
    output logic overflow
);

    logic src_q;
    logic rise;
    logic ovf_set;

    assign rise = src & ~src_q;

    // A new edge on a flag that is still pending (and not being cleared
    // right now) means the earlier event was never serviced.
    assign ovf_set = rise & pending & ~clr;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            src_q    <= 1'b0;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            src_q    <= src;
            // set wins over clear in the same cycle
            pending  <= (pending & ~clr) | rise;
            overflow <= (overflow & ~ovf_clr) | ovf_set;
        end
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt collector: per-source pending/overflow capture, enable
// register, fixed-priority selection (lowest index wins), CPU handshake FSM
// and sticky watchdog NMI.
// Ports:
//   hclk, hreset          : clock, asynchronous active-high reset
//   irq_src               : raw timer interrupt levels
//   wdtimer_nmi           : raw watchdog NMI level
//   en_wr / en_wdata      : enable register write
//   clr_wr / clr_wdata    : write-1-to-clear of pending and overflow
//   nmi_clr               : clears nmi_out
//   irq_ack, irq_eoi      : CPU acknowledge / end-of-interrupt pulses
//   irq_req, irq_id       : request to CPU and index of presented source
//   pending, overflow     : sticky status (enable not applied)
//   irq_en                : current enable register
//   nmi_out               : sticky NMI to CPU
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing presented; pick lowest enabled pending source
// REQ     | irq_req high for irq_id; wait for ack or withdraw
// SERVICE | acknowledged; wait for end-of-interrupt
module timer_irq_ctrl
    import timer_irq_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int ID_W = $clog2(NSRC)
) (
    input  logic            hclk,
    input  logic            hreset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            wdtimer_nmi,
    input  logic            en_wr,
    input  logic [NSRC-1:0] en_wdata,
    input  logic            clr_wr,
    input  logic [NSRC-1:0] clr_wdata,
    input  logic            nmi_clr,
    input  logic            irq_ack,
    input  logic            irq_eoi,
    output logic            irq_req,
    output logic [ID_W-1:0] irq_id,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] overflow,
    output logic [NSRC-1:0] irq_en,
    output logic            nmi_out
);

    irq_state_t      state_q;
    irq_state_t      state_d;
    logic [ID_W-1:0] id_q;
    logic [NSRC-1:0] en_q;
    logic [NSRC-1:0] act;
    logic            act_any;
    logic [ID_W-1:0] act_id;
    logic            cur_act;
    logic            ack_take;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] clr_vec;
    logic            nmi_q;
    logic            nmi_set;

    // ---------------- enable register ----------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            en_q <= '0;
        end else if (en_wr) begin
            en_q <= en_wdata;
        end
    end

    assign irq_en = en_q;

    // ---------------- pending / overflow cells ----------------
    assign clr_vec = clr_wr ? clr_wdata : '0;

    // An ack only counts when the presented source is still active;
    // otherwise the withdraw path wins and nothing is cleared.
    assign cur_act  = act[id_q];
    assign ack_take = (state_q == REQ) && irq_ack && cur_act;
    assign ack_clr  = ack_take ? (NSRC'(1) << id_q) : '0;

    for (genvar i = 0; i < NSRC; i++) begin : g_cell
        irq_pend_cell u_cell (
            .hclk     (hclk),
            .hreset   (hreset),
            .src      (irq_src[i]),
            .clr      (clr_vec[i] | ack_clr[i]),
            .ovf_clr  (clr_vec[i]),
            .pending  (pending[i]),
            .overflow (overflow[i])
        );
    end

    // ---------------- priority encoder ----------------
    assign act = pending & en_q;

    // Scan from the top down so the lowest set index is the last written.
    always_comb begin
        act_any = |act;
        act_id  = '0;
        for (int i = NSRC - 1; i >= SRC_TA; i--) begin
            if (act[i]) begin
                act_id = ID_W'(i);
            end
        end
    end

    // ---------------- handshake FSM ----------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (act_any) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!cur_act) begin
                    state_d = IDLE;
                end else if (irq_ack) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (irq_eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_req = (state_q == REQ);
        irq_id  = id_q;
    end

    // The presented index is frozen on the IDLE->REQ transition so it stays
    // stable for the whole request even if higher-priority events arrive.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            id_q <= '0;
        end else if (state_q == IDLE && act_any) begin
            id_q <= act_id;
        end
    end

    // ---------------- watchdog NMI latch ----------------
    assign nmi_set = wdtimer_nmi & ~nmi_q;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            nmi_q   <= 1'b0;
            nmi_out <= 1'b0;
        end else begin
            nmi_q   <= wdtimer_nmi;
            nmi_out <= (nmi_out & ~nmi_clr) | nmi_set;
        end
    end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
module tb_timer_irq_ctrl;
    import timer_irq_pkg::*;

    logic       hclk = 1'b0;
    logic       hreset = 1'b0;
    logic [3:0] irq_src = '0;
    logic       wdtimer_nmi = 1'b0;
    logic       en_wr = 1'b0;
    logic [3:0] en_wdata = '0;
    logic       clr_wr = 1'b0;
    logic [3:0] clr_wdata = '0;
    logic       nmi_clr = 1'b0;
    logic       irq_ack = 1'b0;
    logic       irq_eoi = 1'b0;
    logic       irq_req;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic [3:0] irq_en;
    logic       nmi_out;

    timer_irq_ctrl dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .irq_src     (irq_src),
        .wdtimer_nmi (wdtimer_nmi),
        .en_wr       (en_wr),
        .en_wdata    (en_wdata),
        .clr_wr      (clr_wr),
        .clr_wdata   (clr_wdata),
        .nmi_clr     (nmi_clr),
        .irq_ack     (irq_ack),
        .irq_eoi     (irq_eoi),
        .irq_req     (irq_req),
        .irq_id      (irq_id),
        .pending     (pending),
        .overflow    (overflow),
        .irq_en      (irq_en),
        .nmi_out     (nmi_out)
    );

    always #5 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       req;
        logic       chk_id;
        logic [1:0] id;
        logic [3:0] pend;
        logic [3:0] ovf;
        logic [3:0] en;
        logic       nmi;
    } exp_t;

    exp_t exp_q[$];
    int   id_q[$];
    int   tests_run = 0;
    int   fails = 0;

    // ---------------- scoreboard push side ----------------
    task automatic chk(input logic req, input logic [1:0] id, input logic [3:0] pend,
                       input logic [3:0] ovf, input logic [3:0] en, input logic nmi);
        exp_t e;
        e.cyc = cyc; e.req = req; e.chk_id = req; e.id = id;
        e.pend = pend; e.ovf = ovf; e.en = en; e.nmi = nmi;
        exp_q.push_back(e);
    endtask

    task automatic chk_rst();
        exp_t e;
        e.cyc = cyc; e.req = 1'b0; e.chk_id = 1'b1; e.id = 2'd0;
        e.pend = '0; e.ovf = '0; e.en = '0; e.nmi = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
        en_wr = 1'b0; clr_wr = 1'b0; nmi_clr = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;
    endtask

    // ---------------- monitor / compare side ----------------
    task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] want);
        tests_run++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %b, want %b", name, cyc, got, want);
        end
    endtask

    exp_t e_m;
    logic req_prev = 1'b0;
    int   want_id;

    always @(negedge hclk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e_m = exp_q.pop_front();
            cmp("irq_req",  {3'b0, irq_req}, {3'b0, e_m.req});
            if (e_m.chk_id) cmp("irq_id", {2'b0, irq_id}, {2'b0, e_m.id});
            cmp("pending",  pending,  e_m.pend);
            cmp("overflow", overflow, e_m.ovf);
            cmp("irq_en",   irq_en,   e_m.en);
            cmp("nmi_out",  {3'b0, nmi_out}, {3'b0, e_m.nmi});
        end
        if (irq_req === 1'b1 && req_prev !== 1'b1) begin
            tests_run++;
            if (id_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_req @cyc %0d: got irq_id %0d, want no request", cyc, irq_id);
            end else begin
                want_id = id_q.pop_front();
                if (int'(irq_id) != want_id) begin
                    fails++;
                    $display("FAIL req_id @cyc %0d: got %0d, want %0d", cyc, irq_id, want_id);
                end
            end
        end
        req_prev = irq_req;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got cyc %0d, want finish", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        #1 hreset = 1'b1;
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;
        chk_rst();

        // single source, full handshake
        en_wr = 1'b1; en_wdata = 4'hF;
        step(); chk(0, 0, 4'b0000, 0, 4'hF, 0);
        irq_src = 4'(1 << SRC_TC);
        step(); chk(0, 0, 4'b0100, 0, 4'hF, 0);
        irq_src = '0;
        id_q.push_back(SRC_TC);
        step(); chk(1, 2, 4'b0100, 0, 4'hF, 0);
        step(); step(); chk(1, 2, 4'b0100, 0, 4'hF, 0);
        irq_ack = 1'b1;
        step(); chk(0, 0, 4'b0000, 0, 4'hF, 0);
        step(); step();
        irq_eoi = 1'b1;
        step(); chk(0, 0, 4'b0000, 0, 4'hF, 0);
        step(); chk(0, 0, 4'b0000, 0, 4'hF, 0);

        // two sources together: priority order
        irq_src = 4'b1010;
        step(); chk(0, 0, 4'b1010, 0, 4'hF, 0);
        irq_src = '0;
        id_q.push_back(SRC_TB);
        step(); chk(1, 1, 4'b1010, 0, 4'hF, 0);
        irq_ack = 1'b1;
        step(); chk(0, 0, 4'b1000, 0, 4'hF, 0);
        irq_eoi = 1'b1;
        step(); chk(0, 0, 4'b1000, 0, 4'hF, 0);
        id_q.push_back(SRC_WDT);
        step(); chk(1, 3, 4'b1000, 0, 4'hF, 0);
        irq_ack = 1'b1;
        step(); chk(0, 0, 4'b0000, 0, 4'hF, 0);
        irq_eoi = 1'b1;
        step(); chk(0, 0, 4'b0000, 0, 4'hF, 0);

        // watchdog 3-cycle level, second rise -> overflow, clear
        irq_src = 4'b1000;
        step(); chk(0, 0, 4'b1000, 0, 4'hF, 0);
        id_q.push_back(SRC_WDT);
        step(); chk(1, 3, 4'b1000, 0, 4'hF, 0);
        step();
        irq_src = '0;
        step(); chk(1, 3, 4'b1000, 4'b0000, 4'hF, 0);
        irq_src = 4'b1000;
        step(); chk(1, 3, 4'b1000, 4'b1000, 4'hF, 0);
        irq_src = '0;
        clr_wr = 1'b1; clr_wdata = 4'b1000;
        step(); chk(1, 3, 4'b0000, 4'b0000, 4'hF, 0);
        step(); chk(0, 0, 4'b0000, 4'b0000, 4'hF, 0);

        // disable presented source before ack -> withdraw, then re-enable
        en_wr = 1'b1; en_wdata = 4'b0001;
        step(); chk(0, 0, 4'b0000, 0, 4'b0001, 0);
        irq_src = 4'(1 << SRC_TA);
        step(); chk(0, 0, 4'b0001, 0, 4'b0001, 0);
        irq_src = '0;
        id_q.push_back(SRC_TA);
        step(); chk(1, 0, 4'b0001, 0, 4'b0001, 0);
        en_wr = 1'b1; en_wdata = 4'b0000;
        step(); chk(1, 0, 4'b0001, 0, 4'b0000, 0);
        step(); chk(0, 0, 4'b0001, 0, 4'b0000, 0);
        en_wr = 1'b1; en_wdata = 4'b0001;
        step(); chk(0, 0, 4'b0001, 0, 4'b0001, 0);
        id_q.push_back(SRC_TA);
        step(); chk(1, 0, 4'b0001, 0, 4'b0001, 0);
        irq_ack = 1'b1;
        step(); chk(0, 0, 4'b0000, 0, 4'b0001, 0);
        irq_eoi = 1'b1;
        step();

        // clear and rise on the same bit; stray ack / eoi
        en_wr = 1'b1; en_wdata = 4'b0000;
        step();
        irq_src = 4'b0001;
        step(); chk(0, 0, 4'b0001, 0, 4'b0000, 0);
        irq_src = '0;
        step();
        irq_src = 4'b0001; clr_wr = 1'b1; clr_wdata = 4'b0001;
        step(); chk(0, 0, 4'b0001, 4'b0000, 4'b0000, 0);
        irq_src = '0;
        irq_ack = 1'b1;
        step(); chk(0, 0, 4'b0001, 0, 4'b0000, 0);
        en_wr = 1'b1; en_wdata = 4'b0001;
        step(); chk(0, 0, 4'b0001, 0, 4'b0001, 0);
        id_q.push_back(SRC_TA);
        step(); chk(1, 0, 4'b0001, 0, 4'b0001, 0);
        irq_eoi = 1'b1;
        step(); chk(1, 0, 4'b0001, 0, 4'b0001, 0);
        irq_ack = 1'b1;
        step(); chk(0, 0, 4'b0000, 0, 4'b0001, 0);

        // NMI path with enables off
        irq_eoi = 1'b1; en_wr = 1'b1; en_wdata = 4'b0000;
        step(); chk(0, 0, 4'b0000, 0, 4'b0000, 0);
        wdtimer_nmi = 1'b1;
        step(); chk(0, 0, 4'b0000, 0, 4'b0000, 1);
        nmi_clr = 1'b1;
        step(); chk(0, 0, 4'b0000, 0, 4'b0000, 0);
        wdtimer_nmi = 1'b0;
        step();
        wdtimer_nmi = 1'b1; nmi_clr = 1'b1;
        step(); chk(0, 0, 4'b0000, 0, 4'b0000, 1);
        wdtimer_nmi = 1'b0; nmi_clr = 1'b1;
        step(); chk(0, 0, 4'b0000, 0, 4'b0000, 0);

        // reset during SERVICE with state everywhere
        en_wr = 1'b1; en_wdata = 4'hF;
        step();
        irq_src = 4'b0010;
        step();
        irq_src = '0;
        id_q.push_back(SRC_TB);
        step(); chk(1, 1, 4'b0010, 0, 4'hF, 0);
        irq_ack = 1'b1;
        step(); chk(0, 0, 4'b0000, 0, 4'hF, 0);
        wdtimer_nmi = 1'b1;
        step();
        wdtimer_nmi = 1'b0; irq_src = 4'b0100;
        step();
        irq_src = '0;
        step();
        irq_src = 4'b0100;
        step();
        irq_src = '0;
        chk(0, 0, 4'b0100, 4'b0100, 4'hF, 1);
        @(negedge hclk);
        #1 hreset = 1'b1;
        #1 chk_rst();
        step();
        hreset = 1'b0;
        chk_rst();
        step(); chk_rst();
        step(); step();

        tests_run++;
        if (exp_q.size() != 0 || id_q.size() != 0) begin
            fails++;
            $display("FAIL queues_drained: got %0d/%0d left, want 0/0", exp_q.size(), id_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
